vdp_vram_slot_arbiter: RTL and testbench

// - Shares the single 32-bit VRAM read/write port among three requesters: super-res display fetch, CPU port, command engine.
// - Time-slots the port into 4-cycle access slots: AP (address present), FS (fetch start), DL (data loading), DR (data ready).
// - The display fetch owns any slot it claims. CPU and command engine share the remaining slots round-robin.
// - Sits between the super high-res pixel fetch logic / CPU / command engine and the SDRAM controller.

---
 rtl/vdp_vram_slot_arbiter_pkg.sv | 28 ++
 rtl/vdp_vram_slot_arbiter_if.sv | 60 ++++++
 rtl/vdp_vram_slot_arbiter_phase_gen.sv | 41 ++++
 rtl/vdp_vram_slot_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vdp_vram_slot_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_vram_slot_arbiter_pkg.sv
// Shared types and constants for the VRAM slot arbiter.
// - slot_phase_t : phase of the 4-cycle VRAM access slot (AP/FS/DL/DR) or IDLE.
// - owner_t      : owner of the in-flight slot.
// - PREFETCH_COL : first column of the forced hblank prefetch slot.
// - PREFETCH_IDLE: column after the prefetch slot; never starts a slot.
package vram_arb_pkg;

  localparam int unsigned CX_W = 11;

  localparam logic [CX_W-1:0] PREFETCH_COL  = 11'd722;
  localparam logic [CX_W-1:0] PREFETCH_IDLE = 11'd726;

  typedef enum logic [2:0] {
    AP,
    FS,
    DL,
    DR,
    IDLE
  } slot_phase_t;

  typedef enum logic [1:0] {
    NONE,
    DISP,
    CPU,
    CMD
  } owner_t;

endpackage

// File: rtl/vdp_vram_slot_arbiter_if.sv
// Requester / VRAM bus bundle for the slot arbiter.
// - disp_* : display fetch request, address, read data and valid pulse.
// - cpu_*  : CPU request/ack handshake with write data, byte enables and read data.
// - cmd_*  : command engine, same set as cpu_*.
// - mem_*  : single 32-bit VRAM port toward the SDRAM controller.
// Modport slave is the arbiter; modport master is the requesters plus memory.
interface vdp_vram_slot_arbiter_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [31:0]       disp_rdata;
  logic              disp_valid;

  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;

  logic              cmd_req;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_be;
  logic              cmd_ack;
  logic [31:0]       cmd_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

  modport slave (
    input  disp_req, disp_addr,
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_be,
    input  cmd_req, cmd_wr, cmd_addr, cmd_wdata, cmd_be,
    input  mem_rdata,
    output disp_rdata, disp_valid,
    output cpu_ack, cpu_rdata,
    output cmd_ack, cmd_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata, mem_be
  );

  modport master (
    output disp_req, disp_addr,
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_be,
    output cmd_req, cmd_wr, cmd_addr, cmd_wdata, cmd_be,
    output mem_rdata,
    input  disp_rdata, disp_valid,
    input  cpu_ack, cpu_rdata,
    input  cmd_ack, cmd_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, mem_be
  );

endinterface

// File: rtl/vdp_vram_slot_arbiter_phase_gen.sv
// Maps the pixel column to the VRAM slot phase.
// - i_cx    : current pixel column.
// - o_phase : AP/FS/DL/DR from cx[1:0] (2/3/0/1), with the hblank prefetch window
//             overriding it and the column after the window forced to IDLE.
module vdp_slot_phase_gen
  import vram_arb_pkg::*;
(
  input  logic [CX_W-1:0] i_cx,
  output slot_phase_t     o_phase
);

  logic       w_in_window;
  logic       w_ap_collides;
  logic [1:0] w_win_off;

  always_comb begin
    w_in_window   = (i_cx >= PREFETCH_COL) && (i_cx <= PREFETCH_COL + 11'd3);
    w_win_off     = 2'(i_cx - PREFETCH_COL);
    // A natural slot whose DR would land inside the prefetch window never starts.
    w_ap_collides = (i_cx < PREFETCH_COL) && (i_cx + 11'd3 >= PREFETCH_COL);
    o_phase       = IDLE;
    if (w_in_window) begin
      case (w_win_off)
        2'd0:    o_phase = AP;
        2'd1:    o_phase = FS;
        2'd2:    o_phase = DL;
        default: o_phase = DR;
      endcase
    end else if (i_cx == PREFETCH_IDLE) begin
      o_phase = IDLE;
    end else begin
      case (i_cx[1:0])
        2'd2:    o_phase = w_ap_collides ? IDLE : AP;
        2'd3:    o_phase = FS;
        2'd0:    o_phase = DL;
        default: o_phase = DR;
      endcase
    end
  end

endmodule

// File: rtl/vdp_vram_slot_arbiter.sv
// Time-slotted arbiter for the shared 32-bit VRAM port.
// - i_clk, i_reset_n : pixel clock, asynchronous active-low reset.
// - i_enable         : super-res active; display requests are ignored when low.
// - i_cx             : current pixel column, drives the slot phase.
// - io_bus           : display / CPU / command-engine requesters and the VRAM port.
// - o_slot_owner     : owner of the in-flight slot (debug).
// Display wins any slot it requests; CPU and command engine share the rest round-robin.
// Grant at AP, strobe in FS, read data and ack/valid at DR (3 cycles after AP).
module vdp_vram_slot_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [CX_W-1:0]         i_cx,
  vdp_vram_slot_arbiter_if.slave  io_bus,
  output owner_t                  o_slot_owner
);

  slot_phase_t       w_phase;
  owner_t            w_grant;
  logic [ADDR_W-1:0] w_g_addr;
  logic              w_g_wr;
  logic [31:0]       w_g_wdata;
  logic [3:0]        w_g_be;

  owner_t            r_owner;
  logic              r_rr_cmd;  // 0 = CPU wins the next contested slot, 1 = CMD
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_disp_valid;
  logic              r_cpu_ack;
  logic              r_cmd_ack;
  logic [31:0]       r_disp_rdata;
  logic [31:0]       r_cpu_rdata;
  logic [31:0]       r_cmd_rdata;

  vdp_slot_phase_gen u_phase_gen (
    .i_cx    (i_cx),
    .o_phase (w_phase)
  );

  always_comb begin
    w_grant = NONE;
    if (i_enable && io_bus.disp_req) begin
      w_grant = DISP;
    end else if (io_bus.cpu_req && io_bus.cmd_req) begin
      w_grant = r_rr_cmd ? CMD : CPU;
    end else if (io_bus.cpu_req) begin
      w_grant = CPU;
    end else if (io_bus.cmd_req) begin
      w_grant = CMD;
    end
  end

  always_comb begin
    w_g_addr  = '0;
    w_g_wr    = 1'b0;
    w_g_wdata = '0;
    w_g_be    = '0;
    case (w_grant)
      DISP: begin
        w_g_addr = io_bus.disp_addr;
      end
      CPU: begin
        w_g_addr  = io_bus.cpu_addr;
        w_g_wr    = io_bus.cpu_wr;
        w_g_wdata = io_bus.cpu_wdata;
        w_g_be    = io_bus.cpu_be;
      end
      CMD: begin
        w_g_addr  = io_bus.cmd_addr;
        w_g_wr    = io_bus.cmd_wr;
        w_g_wdata = io_bus.cmd_wdata;
        w_g_be    = io_bus.cmd_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_owner      <= NONE;
      r_rr_cmd     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_disp_valid <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_cmd_ack    <= 1'b0;
      r_disp_rdata <= '0;
      r_cpu_rdata  <= '0;
      r_cmd_rdata  <= '0;
    end else begin
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_disp_valid <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_cmd_ack    <= 1'b0;
      unique case (w_phase)
        AP: begin
          r_owner <= w_grant;
          // An empty slot keeps the previous address on the bus.
          if (w_grant != NONE) begin
            r_addr   <= w_g_addr;
            r_wdata  <= w_g_wdata;
            r_be     <= w_g_be;
            r_mem_rd <= !w_g_wr;
            r_mem_wr <= w_g_wr;
          end
          if (w_grant == CPU || w_grant == CMD) begin
            r_rr_cmd <= !r_rr_cmd;
          end
        end
        DL: begin
          // Ack is withheld if the requester dropped its request mid-slot.
          case (r_owner)
            DISP:    r_disp_valid <= 1'b1;
            CPU:     r_cpu_ack    <= io_bus.cpu_req;
            CMD:     r_cmd_ack    <= io_bus.cmd_req;
            default: ;
          endcase
        end
        DR: begin
          case (r_owner)
            DISP:    r_disp_rdata <= io_bus.mem_rdata;
            CPU:     r_cpu_rdata  <= io_bus.mem_rdata;
            CMD:     r_cmd_rdata  <= io_bus.mem_rdata;
            default: ;
          endcase
          r_owner <= NONE;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.mem_addr   = r_addr;
  assign io_bus.mem_rd     = r_mem_rd;
  assign io_bus.mem_wr     = r_mem_wr;
  assign io_bus.mem_wdata  = r_wdata;
  assign io_bus.mem_be     = r_be;
  assign io_bus.disp_valid = r_disp_valid;
  assign io_bus.cpu_ack    = r_cpu_ack;
  assign io_bus.cmd_ack    = r_cmd_ack;

  // During DR the read data passes straight through so it lines up with the
  // ack; afterwards the value captured at DR is held.
  assign io_bus.disp_rdata = r_disp_valid ? io_bus.mem_rdata : r_disp_rdata;
  assign io_bus.cpu_rdata  = r_cpu_ack    ? io_bus.mem_rdata : r_cpu_rdata;
  assign io_bus.cmd_rdata  = r_cmd_ack    ? io_bus.mem_rdata : r_cmd_rdata;

  assign o_slot_owner = r_owner;

endmodule

// File: tb/tb_vdp_vram_slot_arbiter.sv
// Directed bench for vdp_vram_slot_arbiter. Column cx is advanced by one per
// clock; outputs are sampled 1 time unit after the rising edge.
module tb_vdp_vram_slot_arbiter;
  import vram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [10:0] cx;
  owner_t      slot_owner;

  int n_tests = 0;
  int n_fail  = 0;

  vdp_vram_slot_arbiter_if #(.ADDR_W(17)) bus ();

  vdp_vram_slot_arbiter #(.ADDR_W(17)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_enable     (enable),
    .i_cx         (cx),
    .io_bus       (bus),
    .o_slot_owner (slot_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cx = cx + 11'd1;
  endtask

  initial begin
    owner_t      exp_o;
    logic [16:0] exp_a;
    int          cpu_acks;
    int          cmd_acks;

    reset_n        = 1'b0;
    enable         = 1'b0;
    cx             = 11'd0;
    bus.disp_req   = 1'b0;
    bus.disp_addr  = '0;
    bus.cpu_req    = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_be     = '0;
    bus.cmd_req    = 1'b0;
    bus.cmd_wr     = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.cmd_be     = '0;
    bus.mem_rdata  = 32'h12345678;
    cpu_acks       = 0;
    cmd_acks       = 0;

    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_disp_valid", bus.disp_valid, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_cmd_ack", bus.cmd_ack, 0);
    chk("rst_disp_rdata", bus.disp_rdata, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_cmd_rdata", bus.cmd_rdata, 0);
    chk("rst_owner", slot_owner, NONE);
    reset_n = 1'b1;

    // CPU read of 0x00100 starting at AP (cx=2)
    cx            = 11'd2;
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = 17'h00100;
    bus.mem_rdata = 32'hCAFE0001;
    next_cycle();  // cx=3 FS
    chk("rd_mem_rd", bus.mem_rd, 1);
    chk("rd_mem_wr", bus.mem_wr, 0);
    chk("rd_mem_addr", bus.mem_addr, 17'h00100);
    chk("rd_owner", slot_owner, CPU);
    next_cycle();  // cx=4 DL
    chk("rd_mem_rd_one_cycle", bus.mem_rd, 0);
    next_cycle();  // cx=5 DR
    chk("rd_cpu_ack", bus.cpu_ack, 1);
    chk("rd_cpu_rdata", bus.cpu_rdata, 32'hCAFE0001);
    bus.cpu_req = 1'b0;
    next_cycle();  // cx=6 AP
    bus.mem_rdata = 32'h11111111;
    chk("rd_ack_pulse", bus.cpu_ack, 0);
    chk("rd_rdata_held", bus.cpu_rdata, 32'hCAFE0001);
    chk("rd_owner_none", slot_owner, NONE);

    // Display and CPU both request at AP (cx=6): display first
    enable         = 1'b1;
    bus.disp_req   = 1'b1;
    bus.disp_addr  = 17'h00200;
    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = 17'h00300;
    bus.mem_rdata  = 32'hD15D15D1;
    next_cycle();  // cx=7
    chk("dc_owner_disp", slot_owner, DISP);
    chk("dc_mem_addr", bus.mem_addr, 17'h00200);
    chk("dc_mem_rd", bus.mem_rd, 1);
    bus.disp_req = 1'b0;
    next_cycle();  // cx=8
    next_cycle();  // cx=9 DR
    chk("dc_disp_valid", bus.disp_valid, 1);
    chk("dc_disp_rdata", bus.disp_rdata, 32'hD15D15D1);
    chk("dc_no_cpu_ack", bus.cpu_ack, 0);
    bus.mem_rdata = 32'h0C0C0C0C;
    next_cycle();  // cx=10 AP
    chk("dc_valid_pulse", bus.disp_valid, 0);
    next_cycle();  // cx=11
    chk("dc_owner_cpu", slot_owner, CPU);
    chk("dc_cpu_addr", bus.mem_addr, 17'h00300);
    next_cycle();  // cx=12
    next_cycle();  // cx=13 DR
    chk("dc_cpu_ack", bus.cpu_ack, 1);
    chk("dc_cpu_rdata", bus.cpu_rdata, 32'h0C0C0C0C);
    bus.cpu_req = 1'b0;
    next_cycle();  // cx=14 AP

    // CPU and CMD held continuously: round-robin starting with CPU
    bus.cpu_req  = 1'b1;
    bus.cmd_req  = 1'b1;
    bus.cmd_wr   = 1'b0;
    bus.cpu_addr = 17'h00500;
    bus.cmd_addr = 17'h00400;
    for (int s = 0; s < 4; s++) begin
      exp_o = (s % 2 == 0) ? CPU : CMD;
      exp_a = (s % 2 == 0) ? 17'h00500 : 17'h00400;
      bus.mem_rdata = 32'hA0000000 | 32'(s);
      next_cycle();
      chk("rr_owner", slot_owner, exp_o);
      chk("rr_mem_addr", bus.mem_addr, exp_a);
      next_cycle();
      next_cycle();
      chk("rr_cpu_ack", bus.cpu_ack, exp_o == CPU);
      chk("rr_cmd_ack", bus.cmd_ack, exp_o == CMD);
      cpu_acks += int'(bus.cpu_ack);
      cmd_acks += int'(bus.cmd_ack);
      next_cycle();
    end
    bus.cpu_req = 1'b0;
    bus.cmd_req = 1'b0;
    chk("rr_cpu_ack_count", 64'(cpu_acks), 2);
    chk("rr_cmd_ack_count", 64'(cmd_acks), 2);

    // CPU write at cx=30 (AP)
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 17'h1FFFF;
    bus.cpu_wdata = 32'hDEADBEEF;
    bus.cpu_be    = 4'b0011;
    next_cycle();  // cx=31 FS
    chk("wr_mem_wr", bus.mem_wr, 1);
    chk("wr_mem_rd", bus.mem_rd, 0);
    chk("wr_mem_addr", bus.mem_addr, 17'h1FFFF);
    chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("wr_mem_be", bus.mem_be, 4'b0011);
    next_cycle();  // cx=32
    chk("wr_mem_wr_one_cycle", bus.mem_wr, 0);
    chk("wr_no_rd_dl", bus.mem_rd, 0);
    next_cycle();  // cx=33 DR
    chk("wr_cpu_ack", bus.cpu_ack, 1);
    chk("wr_no_rd_dr", bus.mem_rd, 0);
    bus.cpu_req = 1'b0;
    bus.cpu_wr  = 1'b0;
    next_cycle();  // cx=34

    // Hblank prefetch window
    cx            = 11'd721;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h00777;
    bus.mem_rdata = 32'h72572500;
    next_cycle();  // cx=722 AP
    chk("pf_no_rd_722", bus.mem_rd, 0);
    next_cycle();  // cx=723 FS
    chk("pf_mem_rd_723", bus.mem_rd, 1);
    chk("pf_owner_723", slot_owner, DISP);
    chk("pf_addr_723", bus.mem_addr, 17'h00777);
    next_cycle();  // cx=724
    next_cycle();  // cx=725 DR
    chk("pf_valid_725", bus.disp_valid, 1);
    chk("pf_rdata_725", bus.disp_rdata, 32'h72572500);
    next_cycle();  // cx=726 IDLE
    chk("pf_owner_726", slot_owner, NONE);
    next_cycle();  // cx=727
    chk("pf_no_ap_726_owner", slot_owner, NONE);
    chk("pf_no_ap_726_rd", bus.mem_rd, 0);
    bus.disp_req = 1'b0;
    enable       = 1'b0;

    // Reset asserted in FS of a CPU slot
    cx            = 11'd2;
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 17'h0ABCD;
    bus.mem_rdata = 32'h5A5A0009;
    next_cycle();  // cx=3 FS
    chk("rs_mem_rd_pre", bus.mem_rd, 1);
    reset_n = 1'b0;
    #1;
    chk("rs_mem_rd_drop", bus.mem_rd, 0);
    chk("rs_owner", slot_owner, NONE);
    chk("rs_mem_addr", bus.mem_addr, 0);
    next_cycle();  // cx=4
    next_cycle();  // cx=5
    chk("rs_no_ack", bus.cpu_ack, 0);
    reset_n = 1'b1;
    next_cycle();  // cx=6 AP
    chk("rs_no_ack_after", bus.cpu_ack, 0);
    next_cycle();  // cx=7 FS
    chk("rs_regrant_owner", slot_owner, CPU);
    chk("rs_regrant_rd", bus.mem_rd, 1);
    chk("rs_regrant_addr", bus.mem_addr, 17'h0ABCD);
    next_cycle();  // cx=8
    next_cycle();  // cx=9 DR
    chk("rs_regrant_ack", bus.cpu_ack, 1);
    chk("rs_regrant_rdata", bus.cpu_rdata, 32'h5A5A0009);
    bus.cpu_req = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
